serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Multi-cycle ripple-borrow subtractor: the inverse datapath of the 32-bit ripple-carry adder. It computes diff = a − b − bin over WIDTH/SLICE clock cycles and processes SLICE bits per cycle through a registered borrow chain. A start/busy/done handshake connects it to a host sequencer. It reports unsigned borrow-out, signed overflow and a zero flag alongside the difference.

## Interface
- WIDTH, 32, operand and result width; must be a multiple of SLICE.
- SLICE, 1, bits processed per cycle; legal values are 1, 2, 4, 8, 16 and 32 (must divide WIDTH).
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only while busy=0.
- a  input  WIDTH  minuend; captured on the accepted start edge.
- b  input  WIDTH  subtrahend; captured on the accepted start edge.
- bin  input  1  borrow-in; captured on the accepted start edge.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; results updated this cycle.
- diff  output  WIDTH  (a − b − bin) mod 2^WIDTH.
- bout  output  1  unsigned borrow-out: 1 iff a < b + bin.
- ovf  output  1  signed overflow: borrow into MSB XOR borrow out of MSB.
- zero  output  1  diff == 0.

## Operation
- States: IDLE, RUN. done is a registered pulse, not a state.
- Reset values: every output is 0. State is IDLE, slice counter is 0, working registers are 0.
- IDLE with start=1:
  - a, b and bin are latched into working registers.
  - The slice counter is cleared to 0 and the machine enters RUN with busy=1.
- RUN, each cycle:
  - Slice k (bits k·SLICE .. k·SLICE+SLICE−1) computes a_k − b_k − borrow. The borrow register initializes to the latched bin.
  - The slice result is written into the working diff register and the borrow register is updated.
  - The counter increments.
- RUN, last slice (counter = WIDTH/SLICE − 1), on the same edge:
  - diff, bout, ovf and zero load from the working result.
  - done=1 and busy=0; the machine returns to IDLE.
- Result outputs (diff, bout, ovf, zero) hold their values until the next done. They do not change while a later operation is in RUN.
- ovf uses the borrow into bit WIDTH−1, captured during the slice that contains the MSB. With SLICE=WIDTH this is a single cycle.
- start while busy=1 is ignored; operands are not re-latched.
- start in the cycle where done=1 is accepted, since busy=0 there. This gives back-to-back operation with no idle gap.
- Operands on a, b and bin may change freely after the accepting edge.
- rst asserted mid-RUN:
  - The operation is abandoned: busy=0, done=0, state IDLE.
  - Result outputs clear to 0.
  - No done is issued for the abandoned operation.
- rst and start high on the same edge: rst wins, and start is not accepted.

## Timing
- N = WIDTH/SLICE; defaults give N = 32.
- Start accepted at edge t: busy=1 from t through t+N−1. At edge t+N, busy=0, done=1 and the results are valid.
- Latency from the accepting edge to done is N cycles. done stays high for exactly one cycle.
- Throughput is one operation per N cycles with back-to-back starts.
- All outputs are registered. No combinational path runs from any input to any output.

## Test plan
- Basic subtract, default parameters:
  - a=1, b=0, bin=0 → done exactly 32 cycles after the start edge; diff=0x00000001, bout=0, ovf=0, zero=0.
- Borrow-out:
  - a=1, b=2, bin=1 → diff=0xFFFFFFFE, bout=1, ovf=0, zero=0.
  - a=0xFFFFFFFF, b=0xFFFFFFFF, bin=1 → diff=0xFFFFFFFF, bout=1, ovf=0.
- Overflow and zero:
  - a=0x80000000, b=1, bin=0 → diff=0x7FFFFFFF, ovf=1, bout=0.
  - a=5, b=5, bin=0 → diff=0, zero=1, bout=0.
- Handshake:
  - Pulse start again at cycle 10 of RUN with different operands → ignored; the original result arrives at cycle 32.
  - Start in the done cycle → second done exactly 32 cycles later.
  - Between the two done pulses, diff holds the first result.
- Reset mid-operation:
  - Assert rst at cycle 15 of RUN → next cycle busy=0, done=0, all results 0; no later done.
  - A subsequent start completes normally.
- Parameter sweep with SLICE ∈ {1, 4, 32}:
  - Apply 1000 random a, b, bin per setting and compare against a reference model of a − b − bin.
  - Check latency = 32/SLICE cycles for each setting.

Source files
------------

// File: rtl/serial_subtractor.sv
// Multi-cycle ripple-borrow subtractor: diff = a - b - bin, SLICE bits per clock
// through a registered borrow chain, with a start/busy/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 32,
  parameter int SLICE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic IDLE = 1'b0;
  localparam logic RUN  = 1'b1;

  logic                   state;
  logic [CW-1:0]          cnt;
  logic [WIDTH-1:0]       a_work;
  logic [WIDTH-1:0]       b_work;
  logic [WIDTH-1:0]       work;
  logic                   borrow;
  logic [SLICE-1:0]       slice_res;
  logic                   slice_bout;
  logic                   msb_bin;
  logic [WIDTH+SLICE-1:0] merged;
  logic [WIDTH-1:0]       next_work;
  logic                   last;

  // Operands shift right each cycle, so the active slice always sits in the low bits.
  always_comb begin
    logic brw;
    brw       = borrow;
    msb_bin   = 1'b0;
    slice_res = '0;
    for (int i = 0; i < SLICE; i++) begin
      if (i == SLICE - 1) msb_bin = brw;
      slice_res[i] = a_work[i] ^ b_work[i] ^ brw;
      brw = (~a_work[i] & b_work[i]) | (~(a_work[i] ^ b_work[i]) & brw);
    end
    slice_bout = brw;
  end

  // Each slice result enters at the top of the working register, ending in place after N cycles.
  assign merged    = {slice_res, work};
  assign next_work = merged[WIDTH+SLICE-1:SLICE];
  assign last      = (cnt == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      a_work <= '0;
      b_work <= '0;
      work   <= '0;
      borrow <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_work <= a;
            b_work <= b;
            borrow <= bin;
            work   <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          a_work <= a_work >> SLICE;
          b_work <= b_work >> SLICE;
          borrow <= slice_bout;
          work   <= next_work;
          cnt    <= cnt + 1'b1;
          if (last) begin
            diff  <= next_work;
            bout  <= slice_bout;
            ovf   <= msb_bin ^ slice_bout;
            zero  <= (next_work == '0);
            done  <= 1'b1;
            busy  <= 1'b0;
            cnt   <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed vectors and handshake sequences on SLICE=1,
// then random operands against an arithmetic model for SLICE = 1, 4 and 32.
module tb_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b;
  logic        bin;
  logic        start_v [3];
  logic        busy_v  [3];
  logic        done_v  [3];
  logic [31:0] diff_v  [3];
  logic        bout_v  [3];
  logic        ovf_v   [3];
  logic        zero_v  [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(32), .SLICE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start_v[0]), .a(a), .b(b), .bin(bin),
    .busy(busy_v[0]), .done(done_v[0]), .diff(diff_v[0]), .bout(bout_v[0]),
    .ovf(ovf_v[0]), .zero(zero_v[0]));

  serial_subtractor #(.WIDTH(32), .SLICE(4)) dut4 (
    .clk(clk), .rst(rst), .start(start_v[1]), .a(a), .b(b), .bin(bin),
    .busy(busy_v[1]), .done(done_v[1]), .diff(diff_v[1]), .bout(bout_v[1]),
    .ovf(ovf_v[1]), .zero(zero_v[1]));

  serial_subtractor #(.WIDTH(32), .SLICE(32)) dut32 (
    .clk(clk), .rst(rst), .start(start_v[2]), .a(a), .b(b), .bin(bin),
    .busy(busy_v[2]), .done(done_v[2]), .diff(diff_v[2]), .bout(bout_v[2]),
    .ovf(ovf_v[2]), .zero(zero_v[2]));

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic [31:0] diff;
    logic        bout;
    logic        ovf;
    logic        zero;
  } vec_t;

  vec_t vecs [5];

  function automatic int slice_of(int k);
    return (k == 0) ? 1 : (k == 1) ? 4 : 32;
  endfunction

  task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Model works on wide integers: the unsigned and signed results of a - b - bin.
  task automatic check_model(string tag, int k, logic [31:0] av, logic [31:0] bv, logic bi);
    longint ua, sr;
    logic [31:0] ed;
    ua = longint'({32'b0, av}) - longint'({32'b0, bv}) - longint'(bi);
    sr = longint'($signed(av)) - longint'($signed(bv)) - longint'(bi);
    ed = ua[31:0];
    check_output({tag, "_diff"}, diff_v[k], ed);
    check_output({tag, "_bout"}, {31'b0, bout_v[k]}, {31'b0, ua < 0});
    check_output({tag, "_ovf"}, {31'b0, ovf_v[k]},
                 {31'b0, (sr > 64'sd2147483647) || (sr < -64'sd2147483648)});
    check_output({tag, "_zero"}, {31'b0, zero_v[k]}, {31'b0, ed == 32'd0});
  endtask

  // Returns #1 after the done edge; lat counts clocks from the accepting edge.
  task automatic apply_stimulus(int k, logic [31:0] av, logic [31:0] bv, logic bi,
                                output int lat);
    @(negedge clk);
    a = av; b = bv; bin = bi; start_v[k] = 1'b1;
    @(posedge clk);
    #1;
    start_v[k] = 1'b0;
    a = $urandom; b = $urandom; bin = 1'($urandom);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!done_v[k] && lat < 200);
  endtask

  initial begin
    int lat;
    int done_seen;
    bit hold_ok;
    logic [31:0] ra, rb;
    logic rbin;

    vecs[0] = '{32'h1,        32'h0,        1'b0, 32'h00000001, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'h1,        32'h2,        1'b1, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{32'h80000000, 32'h1,        1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{32'h5,        32'h5,        1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1};

    rst = 1'b1; a = '0; b = '0; bin = 1'b0;
    for (int k = 0; k < 3; k++) start_v[k] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check_output("reset_busy", {31'b0, busy_v[k]}, 32'd0);
      check_output("reset_done", {31'b0, done_v[k]}, 32'd0);
      check_output("reset_diff", diff_v[k], 32'd0);
      check_output("reset_flags", {29'b0, bout_v[k], ovf_v[k], zero_v[k]}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      apply_stimulus(0, vecs[i].a, vecs[i].b, vecs[i].bin, lat);
      check_output("vec_latency", lat, 32);
      check_output("vec_diff", diff_v[0], vecs[i].diff);
      check_output("vec_bout", {31'b0, bout_v[0]}, {31'b0, vecs[i].bout});
      check_output("vec_ovf", {31'b0, ovf_v[0]}, {31'b0, vecs[i].ovf});
      check_output("vec_zero", {31'b0, zero_v[0]}, {31'b0, vecs[i].zero});
    end
    @(posedge clk);
    #1;
    check_output("done_one_cycle", {31'b0, done_v[0]}, 32'd0);

    // A second start ten cycles into RUN must not disturb the running operation.
    @(negedge clk);
    a = 32'd10; b = 32'd3; bin = 1'b0; start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    lat = 0;
    repeat (10) begin
      @(posedge clk);
      lat++;
    end
    @(negedge clk);
    a = 32'd100; b = 32'd1; bin = 1'b1; start_v[0] = 1'b1;
    @(posedge clk);
    lat++;
    #1;
    start_v[0] = 1'b0;
    while (!done_v[0] && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_output("ignored_start_latency", lat, 32);
    check_output("ignored_start_diff", diff_v[0], 32'd7);

    // Start issued in the done cycle, with the old result held until the next done.
    a = 32'd20; b = 32'd25; bin = 1'b0; start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    lat = 0;
    hold_ok = 1'b1;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (!done_v[0] && diff_v[0] !== 32'd7) hold_ok = 1'b0;
    end while (!done_v[0] && lat < 200);
    check_output("b2b_latency", lat, 32);
    check_output("b2b_hold", {31'b0, hold_ok}, 32'd1);
    check_model("b2b", 0, 32'd20, 32'd25, 1'b0);

    @(negedge clk);
    a = 32'h12345678; b = 32'h1; bin = 1'b0; start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_output("midrst_busy", {31'b0, busy_v[0]}, 32'd0);
    check_output("midrst_done", {31'b0, done_v[0]}, 32'd0);
    check_output("midrst_diff", diff_v[0], 32'd0);
    check_output("midrst_flags", {29'b0, bout_v[0], ovf_v[0], zero_v[0]}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done_v[0]) done_seen++;
    end
    check_output("midrst_no_done", done_seen, 0);
    apply_stimulus(0, 32'd9, 32'd4, 1'b1, lat);
    check_output("after_rst_latency", lat, 32);
    check_model("after_rst", 0, 32'd9, 32'd4, 1'b1);

    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 1000; n++) begin
        ra = $urandom;
        rb = (n % 8 == 0) ? ra : $urandom;
        rbin = 1'($urandom);
        apply_stimulus(k, ra, rb, rbin, lat);
        check_output("rand_latency", lat, 32 / slice_of(k));
        check_model("rand", k, ra, rb, rbin);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
